// File: rtl/out_share_arbiter.sv
// out_share_arbiter: round-robin arbiter that lets one requester at a time drive a shared output bit.
// Ports: clk, rst (sync, active-high); req/data_in per requester;
// grant (registered, one-hot-or-zero), out/out_valid (registered shared data), busy (HOLD or GAP).
module out_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int HOLD    = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] data_in,
   output logic [NUM_REQ-1:0] grant,
   output logic               out,
   output logic               out_valid,
   output logic               busy
);
   localparam int PW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;
   state_t state, state_nxt;
   logic [PW-1:0] ptr, winner, pick;
   logic [3:0] cnt;
   logic rel;
   assign rel = cnt == 4'd0 || !req[winner];
   always_ff @(posedge clk)
      state <= rst ? S_IDLE : state_nxt;
   always_comb
      state_nxt = state == S_HOLD ? (rel ? S_GAP : S_HOLD) : (|req ? S_HOLD : S_IDLE);
   always_comb
      busy = state != S_IDLE;
   // Scan downwards so the last hit is the first request at or after ptr.
   always_comb begin
      int j;
      pick = '0;
      j = 0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         j = int'(ptr) + i;
         j = j >= NUM_REQ ? j - NUM_REQ : j;
         if (req[j]) pick = PW'(j);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         grant     <= '0;
         out       <= 1'b0;
         out_valid <= 1'b0;
         ptr       <= '0;
         winner    <= '0;
         cnt       <= 4'd0;
      end else begin
         out_valid <= state == S_HOLD;
         if (state == S_HOLD) begin
            out <= data_in[winner];
            if (rel) begin
               grant <= '0;
               ptr   <= winner == PW'(NUM_REQ-1) ? '0 : winner + PW'(1);
            end else
               cnt <= cnt - 4'd1;
         end else if (|req) begin
            grant  <= NUM_REQ'(1) << pick;
            winner <= pick;
            cnt    <= 4'(HOLD-1);
         end else
            grant <= '0;
      end
   end
endmodule

// File: doc/out_share_arbiter.md
OUT_SHARE_ARBITER -- requirements
Module: out_share_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the output net (2..8).
REQ-002 SHALL have parameter HOLD, default 3, maximum grant tenure in cycles (1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port req, input, NUM_REQ, per-requester request for the shared output.
REQ-006 SHALL have port data_in, input, NUM_REQ, per-requester data bit.
REQ-007 SHALL have port grant, output, NUM_REQ, one-hot-or-zero grant, registered.
REQ-008 SHALL have port out, output, 1, shared output bit, registered.
REQ-009 SHALL have port out_valid, output, 1, high when out carries granted data.
REQ-010 SHALL have port busy, output, 1, high while in the HOLD or GAP state.

Function
REQ-011 SHALL implement states IDLE, HOLD and GAP, with a round-robin pointer ptr (0..NUM_REQ-1) and a tenure counter cnt.
REQ-012 In IDLE or GAP with req nonzero, SHALL select the winner as the first asserted req index at or after ptr, wrapping modulo NUM_REQ; next cycle: state HOLD, grant=onehot(winner), cnt=HOLD-1.
REQ-013 In IDLE or GAP with req zero, SHALL go to or stay in IDLE with grant=0.
REQ-014 In HOLD, SHALL register out<=data_in[winner] and out_valid<=1 each cycle, so out lags data_in by one cycle.
REQ-015 In HOLD, SHALL decrement cnt each cycle while req[winner]=1 and cnt>0.
REQ-016 SHALL leave HOLD for GAP when cnt==0 or req[winner]==0 (early release); at that edge: grant=0, ptr=(winner+1) mod NUM_REQ.
REQ-017 GAP SHALL last exactly one cycle, giving exactly one grant=0 cycle between any two consecutive grants, including re-grant to the same requester.
REQ-018 out_valid SHALL be 0 in every cycle after a cycle in which grant was 0; out SHALL hold its last value when out_valid=0.
REQ-019 grant SHALL never have more than one bit set.
REQ-020 Requests arriving during HOLD SHALL be ignored until GAP; no request is latched, and a request deasserted before GAP is lost.
REQ-021 With HOLD=1, a grant SHALL last exactly one cycle.

Reset
REQ-022 When rst=1 at a clock edge: state=IDLE, grant=0, out=0, out_valid=0, busy=0, ptr=0, cnt=0, regardless of current state.
REQ-023 rst SHALL take priority over all other inputs; the first arbitration after reset release starts from ptr=0.

Verification
REQ-024 Reset, then req=4'b0001 held, data_in[0]=1 -> grant=0001 for 3 cycles, then 1 gap cycle, then grant=0001 again; out_valid high one cycle after each grant cycle, out=1.
REQ-025 req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001, each lasting 3 cycles with a single zero-grant cycle between grants.
REQ-026 req=4'b0001, then req[0] dropped on the 2nd grant cycle -> grant=0 on the next edge, GAP, IDLE; ptr=1.
REQ-027 ptr=3 with req=4'b0101 -> winner index 0 (wrap-around); next winner index 2.
REQ-028 rst asserted mid-HOLD with grant=0100 -> next cycle grant=0, out=0, out_valid=0, busy=0; after release with req=4'b0100 -> grant=0100.
REQ-029 A checker SHALL assert grant is one-hot-or-zero, and out_valid implies grant was nonzero in the previous cycle, for every cycle of all scenarios.
